// File: rtl/quad_row_writer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// quad_pkg : shared geometry constants, vertex types and FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package quad_pkg;

  localparam int WARP_WIDTH    = 320;
  localparam int SCREEN_H      = 240;
  localparam int PIX_PER_WORD  = 16;
  localparam int WORDS_PER_ROW = WARP_WIDTH / PIX_PER_WORD;
  localparam int COLOR_W       = 8;
  localparam int FB_ADDR_W     = 13;
  localparam int COORD_W       = 10;
  localparam int WORD_IDX_W    = $clog2(WORDS_PER_ROW);

  typedef logic [COORD_W-1:0] coord_t;
  typedef coord_t  [1:0] vertex_t;   // [0] = x, [1] = y
  typedef vertex_t [3:0] quad_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    ROW_WAIT = 3'd2,
    EMIT     = 3'd3,
    NEXT_ROW = 3'd4,
    FINISH   = 3'd5
  } qrw_state_e;

  function automatic coord_t quad_y_min(input quad_t q);
    coord_t m;
    m = q[0][1];
    for (int i = 1; i < 4; i++) begin
      if (q[i][1] < m) m = q[i][1];
    end
    return m;
  endfunction

  function automatic coord_t quad_y_max(input quad_t q);
    coord_t m;
    m = q[0][1];
    for (int i = 1; i < 4; i++) begin
      if (q[i][1] > m) m = q[i][1];
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_row_writer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// quad_row_writer_if : command, rasterizer and framebuffer-write bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface quad_row_writer_if;
  import quad_pkg::*;

  logic                    cmd_valid;
  logic                    cmd_ready;
  quad_t                   cmd_vertices;
  logic [COLOR_W-1:0]      cmd_color;
  quad_t                   rast_vertices;
  coord_t                  drawY;
  logic [WARP_WIDTH-1:0]   isInside;
  logic                    fb_we;
  logic                    fb_ready;
  logic [FB_ADDR_W-1:0]    fb_addr;
  logic [PIX_PER_WORD-1:0] fb_pix_mask;
  logic [COLOR_W-1:0]      fb_color;
  logic                    done;

  modport master (
    output cmd_valid, cmd_vertices, cmd_color, isInside, fb_ready,
    input  cmd_ready, rast_vertices, drawY, fb_we, fb_addr, fb_pix_mask,
           fb_color, done
  );

  modport slave (
    input  cmd_valid, cmd_vertices, cmd_color, isInside, fb_ready,
    output cmd_ready, rast_vertices, drawY, fb_we, fb_addr, fb_pix_mask,
           fb_color, done
  );

endinterface
`default_nettype wire

// File: rtl/quad_row_writer_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// quad_row_serializer : buffers one coverage row and streams it as masked
// framebuffer words. QUAD_SKIP_EMPTY_EN skips all-zero-mask words.
// Rev 1.0
// ----------------------------------------------------------------------------
module quad_row_serializer
  import quad_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [WARP_WIDTH-1:0]   row_in,
  input  coord_t                  row_y,
  input  logic [COLOR_W-1:0]      color,
  input  logic                    fb_ready,
  output logic                    fb_we,
  output logic [FB_ADDR_W-1:0]    fb_addr,
  output logic [PIX_PER_WORD-1:0] fb_pix_mask,
  output logic [COLOR_W-1:0]      fb_color,
  output logic                    row_done
);

  typedef logic [WORDS_PER_ROW-1:0][PIX_PER_WORD-1:0] row_buf_t;

  row_buf_t                row_buf_q, row_buf_d;
  logic [WORD_IDX_W-1:0]   word_q, word_d;
  logic                    busy_q, busy_d;
  logic [PIX_PER_WORD-1:0] cur_mask;
  logic                    advance;
  logic                    last_word;

  assign cur_mask = row_buf_q[word_q];

`ifdef QUAD_SKIP_EMPTY_EN
  assign fb_we = busy_q && (cur_mask != '0);
`else
  assign fb_we = busy_q;
`endif

  // A skipped word (busy without fb_we) advances unconditionally
  assign advance   = busy_q && (fb_ready || !fb_we);
  assign last_word = (word_q == WORD_IDX_W'(WORDS_PER_ROW - 1));
  assign row_done  = advance && last_word;

  assign fb_addr     = FB_ADDR_W'(row_y) * FB_ADDR_W'(WORDS_PER_ROW)
                     + FB_ADDR_W'(word_q);
  assign fb_pix_mask = busy_q ? cur_mask : '0;
  assign fb_color    = color;

  always_comb begin
    row_buf_d = row_buf_q;
    word_d    = word_q;
    busy_d    = busy_q;
    if (load) begin
      row_buf_d = row_in;
      word_d    = '0;
      busy_d    = 1'b1;
    end else if (advance) begin
      if (last_word) begin
        busy_d = 1'b0;
      end else begin
        word_d = word_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_buf_q <= '0;
      word_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      row_buf_q <= row_buf_d;
      word_q    <= word_d;
      busy_q    <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/quad_row_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// quad_row_writer : sweeps drawY over a quad's clamped y-range and streams each
// coverage row as masked framebuffer writes. Option: QUAD_SKIP_EMPTY_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module quad_row_writer
  import quad_pkg::*;
#(
  parameter int RAST_LAT = 1
)
(
  input  logic               Clk,
  input  logic               Reset,
  quad_row_writer_if.slave   bus
);

  localparam logic [1:0] LAT_LAST = 2'(RAST_LAT - 1);

  qrw_state_e         state_q, state_d;
  quad_t              verts_q, verts_d;
  logic [COLOR_W-1:0] color_q, color_d;
  coord_t             draw_y_q, draw_y_d;
  coord_t             y_max_q, y_max_d;
  logic [1:0]         lat_cnt_q, lat_cnt_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               done_q, done_d;

  coord_t             y_lo, y_hi_raw, y_hi;
  logic               load_row;
  logic               row_done;

  assign y_lo     = quad_y_min(verts_q);
  assign y_hi_raw = quad_y_max(verts_q);
  assign y_hi     = (y_hi_raw > coord_t'(SCREEN_H - 1)) ? coord_t'(SCREEN_H - 1)
                                                        : y_hi_raw;

  always_comb begin
    state_d   = state_q;
    verts_d   = verts_q;
    color_d   = color_q;
    draw_y_d  = draw_y_q;
    y_max_d   = y_max_q;
    lat_cnt_d = lat_cnt_q;
    load_row  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          verts_d = bus.cmd_vertices;
          color_d = bus.cmd_color;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // Quad entirely below the visible area produces no rows at all
        if (y_lo > y_hi) begin
          state_d = FINISH;
        end else begin
          draw_y_d  = y_lo;
          y_max_d   = y_hi;
          lat_cnt_d = '0;
          state_d   = ROW_WAIT;
        end
      end
      ROW_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          load_row = 1'b1;
          state_d  = EMIT;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      EMIT: begin
        if (row_done) state_d = NEXT_ROW;
      end
      NEXT_ROW: begin
        if (draw_y_q == y_max_q) begin
          state_d = FINISH;
        end else begin
          draw_y_d  = draw_y_q + 1'b1;
          lat_cnt_d = '0;
          state_d   = ROW_WAIT;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    done_d      = (state_d == FINISH);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      verts_q     <= '0;
      color_q     <= '0;
      draw_y_q    <= '0;
      y_max_q     <= '0;
      lat_cnt_q   <= '0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      verts_q     <= verts_d;
      color_q     <= color_d;
      draw_y_q    <= draw_y_d;
      y_max_q     <= y_max_d;
      lat_cnt_q   <= lat_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
    end
  end

  quad_row_serializer u_ser (
    .clk         (Clk),
    .rst         (Reset),
    .load        (load_row),
    .row_in      (bus.isInside),
    .row_y       (draw_y_q),
    .color       (color_q),
    .fb_ready    (bus.fb_ready),
    .fb_we       (bus.fb_we),
    .fb_addr     (bus.fb_addr),
    .fb_pix_mask (bus.fb_pix_mask),
    .fb_color    (bus.fb_color),
    .row_done    (row_done)
  );

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rast_vertices = verts_q;
  assign bus.drawY         = draw_y_q;
  assign bus.done          = done_q;

endmodule
`default_nettype wire
